// File: rtl/serial_word_tx.sv
// serial_word_tx: buffers parallel words in a small FIFO and streams them MSB-first
// on a single serial line, reloading back-to-back so consecutive words have no gap.
module serial_word_tx #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             so,
   output logic             so_valid,
   output logic             frame_last,
   output logic             busy
);
   localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CNW = $clog2(DEPTH + 1);
   localparam int BW  = WIDTH > 1 ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CNW-1:0]   count_q, count_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic             push, pop, empty;

   assign empty     = count_q == '0;
   assign din_ready = count_q != CNW'(DEPTH);
   assign push      = din_valid && din_ready;
   // reload on the last bit's edge so back-to-back words carry no idle bit
   assign pop       = !empty && (state_q == IDLE || bcnt_q == '0);

   assign so         = state_q == SHIFT && shreg_q[WIDTH-1];
   assign so_valid   = state_q == SHIFT;
   assign frame_last = state_q == SHIFT && bcnt_q == '0;
   assign busy       = state_q == SHIFT || !empty;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bcnt_d  = bcnt_q;
      count_d = count_q + CNW'(push) - CNW'(pop);
      if (pop) begin
         state_d = SHIFT;
         shreg_d = mem_q[rptr_q];
         bcnt_d  = BW'(WIDTH - 1);
      end else if (state_q == SHIFT) begin
         shreg_d = shreg_q << 1;
         bcnt_d  = bcnt_q - BW'(1);
         state_d = bcnt_q == '0 ? IDLE : SHIFT;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bcnt_q  <= '0;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bcnt_q  <= bcnt_d;
         count_q <= count_d;
         wptr_q  <= push ? wptr_q + AW'(1) : wptr_q;
         rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= din;
   end
endmodule
